// File: rtl/arp_ctrl_if.sv
// arp_ctrl_if: receive/request events in, transmit control and resolution status out.
// The controller binds to slave, the stimulus side to master.
interface arp_ctrl_if;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        req_start;
    logic [31:0] req_ip;
    logic        tx_done;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        busy;
    logic        resolved;
    logic [47:0] resolved_mac;
    logic        resolve_fail;

    modport master (
        output arp_rx_done, arp_rx_type, src_mac, src_ip,
        output req_start, req_ip, tx_done,
        input  arp_tx_en, arp_tx_type, des_mac, des_ip,
        input  busy, resolved, resolved_mac, resolve_fail
    );

    modport slave (
        input  arp_rx_done, arp_rx_type, src_mac, src_ip,
        input  req_start, req_ip, tx_done,
        output arp_tx_en, arp_tx_type, des_mac, des_ip,
        output busy, resolved, resolved_mac, resolve_fail
    );
endinterface

// File: rtl/arp_ctrl.sv
// arp_ctrl: ARP transmit scheduler (reply/request arbitration, retries, resolution).
// Define ARP_CTRL_GRATUITOUS_EN to queue one gratuitous request after reset.
module arp_ctrl #(
    parameter logic [31:0] BOARD_IP     = 32'hC0_A8_00_02,
    parameter int          RETRY_CYCLES = 125_000_000,
    parameter int          MAX_TRY      = 3
) (
    input  logic      clk,
    input  logic      rst,
    arp_ctrl_if.slave bus
);

`ifdef ARP_CTRL_GRATUITOUS_EN
    localparam logic GRAT_EN = 1'b1;
`else
    localparam logic GRAT_EN = 1'b0;
`endif

    localparam int TW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_MAX = TW'(RETRY_CYCLES - 1);
    localparam logic [3:0]    MAXT    = 4'(MAX_TRY);
    localparam logic [47:0]   BCAST   = {48{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE
    } state_t;

    state_t      r_state;
    logic        r_launch_cnt;

    logic        r_rx_done;
    logic        r_rx_type;
    logic [47:0] r_src_mac;
    logic [31:0] r_src_ip;
    logic        r_req_start;
    logic [31:0] r_req_ip;

    logic        r_reply_pend;
    logic [47:0] r_reply_mac;
    logic [31:0] r_reply_ip;
    logic        r_req_pend;
    logic        r_req_active;
    logic [31:0] r_tgt_ip;
    logic [3:0]  r_try_cnt;
    logic [TW-1:0] r_tmr;
    logic        r_grat_arm;
    logic        r_grat_pend;

    logic        r_tx_en;
    logic        r_tx_type;
    logic [47:0] r_des_mac;
    logic [31:0] r_des_ip;
    logic        r_busy;
    logic        r_resolved;
    logic [47:0] r_resolved_mac;
    logic        r_resolve_fail;

    logic w_idle;
    logic w_rx_req;
    logic w_rx_match;
    logic w_tmr_run;
    logic w_tmr_exp;
    logic w_ld_reply;
    logic w_ld_req;
    logic w_ld_grat;

    assign w_idle     = (r_state == S_IDLE);
    assign w_rx_req   = r_rx_done & ~r_rx_type;
    // A req_start in the same cycle retargets, so the reply is stale.
    assign w_rx_match = r_rx_done & r_rx_type & r_req_active
                      & ~r_req_start & (r_src_ip == r_tgt_ip);
    assign w_tmr_run  = r_req_active & ~r_req_pend & (r_state != S_LAUNCH);
    assign w_tmr_exp  = w_tmr_run & (r_tmr == TMR_MAX);
    assign w_ld_reply = w_idle & r_reply_pend;
    assign w_ld_req   = w_idle & ~r_reply_pend & r_req_pend;
    assign w_ld_grat  = w_idle & ~r_reply_pend & ~r_req_pend & r_grat_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_launch_cnt   <= 1'b0;
            r_rx_done      <= 1'b0;
            r_rx_type      <= 1'b0;
            r_src_mac      <= '0;
            r_src_ip       <= '0;
            r_req_start    <= 1'b0;
            r_req_ip       <= '0;
            r_reply_pend   <= 1'b0;
            r_reply_mac    <= '0;
            r_reply_ip     <= '0;
            r_req_pend     <= 1'b0;
            r_req_active   <= 1'b0;
            r_tgt_ip       <= '0;
            r_try_cnt      <= '0;
            r_tmr          <= '0;
            r_grat_arm     <= GRAT_EN;
            r_grat_pend    <= 1'b0;
            r_tx_en        <= 1'b0;
            r_tx_type      <= 1'b0;
            r_des_mac      <= '0;
            r_des_ip       <= '0;
            r_busy         <= 1'b0;
            r_resolved     <= 1'b0;
            r_resolved_mac <= '0;
            r_resolve_fail <= 1'b0;
        end else begin
            r_rx_done      <= bus.arp_rx_done;
            r_rx_type      <= bus.arp_rx_type;
            r_src_mac      <= bus.src_mac;
            r_src_ip       <= bus.src_ip;
            r_req_start    <= bus.req_start;
            r_req_ip       <= bus.req_ip;
            r_resolve_fail <= 1'b0;
            r_grat_arm     <= 1'b0;

            if (r_grat_arm)
                r_grat_pend <= 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    unique case (1'b1)
                        w_ld_reply: begin
                            r_des_mac    <= r_reply_mac;
                            r_des_ip     <= r_reply_ip;
                            r_tx_type    <= 1'b1;
                            r_reply_pend <= 1'b0;
                        end
                        w_ld_req: begin
                            r_des_mac  <= BCAST;
                            r_des_ip   <= r_tgt_ip;
                            r_tx_type  <= 1'b0;
                            r_req_pend <= 1'b0;
                            r_try_cnt  <= r_try_cnt + 4'd1;
                        end
                        w_ld_grat: begin
                            r_des_mac   <= BCAST;
                            r_des_ip    <= BOARD_IP;
                            r_tx_type   <= 1'b0;
                            r_grat_pend <= 1'b0;
                        end
                        default: ;
                    endcase
                    if (w_ld_reply | w_ld_req | w_ld_grat) begin
                        r_state      <= S_LAUNCH;
                        r_tx_en      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_launch_cnt <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    if (r_launch_cnt) begin
                        r_tx_en <= 1'b0;
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_launch_cnt <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Latest requester wins; a new arrival survives a same-cycle load.
            if (w_rx_req) begin
                r_reply_pend <= 1'b1;
                r_reply_mac  <= r_src_mac;
                r_reply_ip   <= r_src_ip;
            end

            if (w_tmr_exp)
                r_tmr <= '0;
            else if (w_tmr_run)
                r_tmr <= r_tmr + 1'b1;

            if (w_tmr_exp && !w_rx_match) begin
                if (r_try_cnt < MAXT) begin
                    r_req_pend <= 1'b1;
                end else begin
                    r_resolve_fail <= 1'b1;
                    r_req_active   <= 1'b0;
                end
            end

            if (w_rx_match) begin
                r_resolved     <= 1'b1;
                r_resolved_mac <= r_src_mac;
                r_req_active   <= 1'b0;
                r_req_pend     <= 1'b0;
            end

            if (r_req_start) begin
                r_tgt_ip       <= r_req_ip;
                r_resolved     <= 1'b0;
                r_resolved_mac <= '0;
                r_try_cnt      <= '0;
                r_tmr          <= '0;
                r_req_active   <= 1'b1;
                r_req_pend     <= 1'b1;
            end
        end
    end

    assign bus.arp_tx_en    = r_tx_en;
    assign bus.arp_tx_type  = r_tx_type;
    assign bus.des_mac      = r_des_mac;
    assign bus.des_ip       = r_des_ip;
    assign bus.busy         = r_busy;
    assign bus.resolved     = r_resolved;
    assign bus.resolved_mac = r_resolved_mac;
    assign bus.resolve_fail = r_resolve_fail;

endmodule

// File: tb/tb_arp_ctrl.sv
// tb_arp_ctrl: randomized scoreboard bench for arp_ctrl with a behavioural
// transmitter and a frame-level reference of the expected ARP traffic.
module tb_arp_ctrl;

    localparam int          RETRY    = 100;
    localparam int          MAXT     = 3;
    localparam logic [31:0] BOARD_IP = 32'hC0_A8_00_02;
    localparam logic [47:0] BCAST    = {48{1'b1}};

    typedef struct {
        logic        t;
        logic [47:0] mac;
        logic [31:0] ip;
    } frm_t;

    logic clk;
    logic rst = 1'b1;

    arp_ctrl_if bus();

    arp_ctrl #(
        .BOARD_IP    (BOARD_IP),
        .RETRY_CYCLES(RETRY),
        .MAX_TRY     (MAXT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    frm_t exp_q[$];
    int   req_rise[$];
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Behavioural transmitter: answers each frame with tx_done after a random delay.
    int tx_wait = 0;
    bit tx_prev = 0;
    bit tx_stall = 0;

    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            if (rst) begin
                tx_wait = 0;
            end else if (bus.arp_tx_en && !tx_prev) begin
                tx_wait = 2 + int'($urandom_range(3, 12));
            end else if (tx_wait > 0 && !tx_stall) begin
                tx_wait--;
                if (tx_wait == 0)
                    bus.tx_done = 1'b1;
            end
            tx_prev = bus.arp_tx_en;
        end
    end

    // Monitor: pops the scoreboard on each frame launch.
    bit          prev_en = 0;
    bit          in_fl = 0;
    bit          have;
    bit          hold_bad;
    bit          busy_bad;
    int          en_len = 0;
    int          idle_busy_bad = 0;
    int          n_failp = 0;
    int          n_frames = 0;
    frm_t        f;
    logic        cur_t;
    logic [47:0] cur_mac;
    logic [31:0] cur_ip;

    always @(negedge clk) begin
        if (rst) begin
            in_fl   = 0;
            prev_en = 0;
            en_len  = 0;
        end else begin
            if (bus.arp_tx_en && !prev_en) begin
                have = (exp_q.size() != 0);
                chk("frame_expected", have, 1);
                if (have) begin
                    f = exp_q.pop_front();
                    chk("tx_type", bus.arp_tx_type, f.t);
                    chk("des_mac", bus.des_mac, f.mac);
                    chk("des_ip", bus.des_ip, f.ip);
                end
                cur_t    = bus.arp_tx_type;
                cur_mac  = bus.des_mac;
                cur_ip   = bus.des_ip;
                in_fl    = 1;
                en_len   = 0;
                hold_bad = 0;
                busy_bad = 0;
                n_frames++;
                if (!bus.arp_tx_type)
                    req_rise.push_back(cyc);
            end
            if (bus.arp_tx_en)
                en_len++;
            if (!bus.arp_tx_en && prev_en)
                chk("tx_en_len", en_len, 2);
            if (in_fl) begin
                if (bus.arp_tx_type !== cur_t || bus.des_mac !== cur_mac
                    || bus.des_ip !== cur_ip)
                    hold_bad = 1;
                if (!bus.busy)
                    busy_bad = 1;
                if (bus.tx_done) begin
                    chk("hold_until_done", hold_bad, 0);
                    chk("busy_in_flight", busy_bad, 0);
                    in_fl = 0;
                end
            end else if (bus.busy) begin
                idle_busy_bad++;
            end
            if (bus.resolve_fail)
                n_failp++;
            prev_en = bus.arp_tx_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic t, input logic [47:0] m, input logic [31:0] ip);
        frm_t e;
        e.t   = t;
        e.mac = m;
        e.ip  = ip;
        exp_q.push_back(e);
    endtask

    task automatic rx_pulse(input logic t, input logic [47:0] m, input logic [31:0] ip);
        bus.arp_rx_done = 1'b1;
        bus.arp_rx_type = t;
        bus.src_mac     = m;
        bus.src_ip      = ip;
        tick();
        bus.arp_rx_done = 1'b0;
    endtask

    task automatic req_pulse(input logic [31:0] ip);
        bus.req_start = 1'b1;
        bus.req_ip    = ip;
        tick();
        bus.req_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && !in_fl && !bus.arp_tx_en && !bus.busy) begin
                ok = 1;
                break;
            end
        end
        chk("idle_reached", ok, 1);
    endtask

    task automatic wait_rise(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.arp_tx_en) begin
                ok = 1;
                break;
            end
        end
        chk("tx_en_rise", ok, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx_en"}, bus.arp_tx_en, 0);
        chk({tag, "_tx_type"}, bus.arp_tx_type, 0);
        chk({tag, "_des_mac"}, bus.des_mac, 0);
        chk({tag, "_des_ip"}, bus.des_ip, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_resolved"}, bus.resolved, 0);
        chk({tag, "_resolved_mac"}, bus.resolved_mac, 0);
        chk({tag, "_resolve_fail"}, bus.resolve_fail, 0);
    endtask

    function automatic logic [47:0] rmac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    logic [47:0] m_a, m_b, m_x;
    logic [31:0] ip_a, ip_b, ip_x, tgt;
    int          fp0, fr0, g;

    initial begin
        bus.arp_rx_done = 1'b0;
        bus.arp_rx_type = 1'b0;
        bus.src_mac     = '0;
        bus.src_ip      = '0;
        bus.req_start   = 1'b0;
        bus.req_ip      = '0;

        tick();
        tick();
        chk_reset("por");
`ifdef ARP_CTRL_GRATUITOUS_EN
        push(1'b0, BCAST, BOARD_IP);
`endif
        rst = 1'b0;
        wait_idle(50);

        // Reply with pulse-to-enable latency.
        m_a  = 48'h11_22_33_44_55_66;
        ip_a = 32'hC0A80003;
        push(1'b1, m_a, ip_a);
        rx_pulse(1'b0, m_a, ip_a);
        tick();
        chk("lat_n1_tx_en", bus.arp_tx_en, 0);
        tick();
        chk("lat_n2_tx_en", bus.arp_tx_en, 1);
        tick();
        chk("lat_n3_tx_en", bus.arp_tx_en, 1);
        tick();
        chk("lat_n4_tx_en", bus.arp_tx_en, 0);
        wait_idle(50);

        // Random replies; a second and third request during a frame: latest wins.
        for (int i = 0; i < 6; i++) begin
            m_x = rmac(); ip_x = $urandom;
            m_a = rmac(); ip_a = $urandom;
            m_b = rmac(); ip_b = $urandom;
            push(1'b1, m_x, ip_x);
            rx_pulse(1'b0, m_x, ip_x);
            wait_rise(10);
            rx_pulse(1'b0, m_a, ip_a);
            rx_pulse(1'b0, m_b, ip_b);
            push(1'b1, m_b, ip_b);
            wait_idle(100);
            rx_pulse(1'b1, rmac(), $urandom);
            for (int k = 0; k < 8; k++) tick();
            chk("stray_reply_resolved", bus.resolved, 0);
        end

        // Resolve, then no further requests.
        tgt = 32'hC0A80003;
        push(1'b0, BCAST, tgt);
        req_pulse(tgt);
        wait_idle(50);
        m_a = 48'h11_22_33_44_55_66;
        rx_pulse(1'b1, m_a, tgt);
        tick();
        chk("resolved", bus.resolved, 1);
        chk("resolved_mac", bus.resolved_mac, m_a);
        fr0 = n_frames;
        for (int k = 0; k < 3 * RETRY; k++) tick();
        chk("no_retry_after_resolve", n_frames - fr0, 0);
        chk("resolved_held", bus.resolved, 1);

        // Non-matching reply is ignored and retries continue.
        tgt = 32'hC0A80003;
        push(1'b0, BCAST, tgt);
        req_pulse(tgt);
        tick();
        chk("req_clears_resolved", bus.resolved, 0);
        chk("req_clears_mac", bus.resolved_mac, 0);
        wait_idle(50);
        rx_pulse(1'b1, rmac(), 32'hC0A80009);
        tick();
        chk("nonmatch_resolved", bus.resolved, 0);
        push(1'b0, BCAST, tgt);
        wait_idle(3 * RETRY);
        m_b = rmac();
        rx_pulse(1'b1, m_b, tgt);
        tick();
        chk("retry_resolved", bus.resolved, 1);
        chk("retry_resolved_mac", bus.resolved_mac, m_b);

        // Arbitration: same-cycle req_start and incoming request.
        m_a = rmac(); ip_a = $urandom; tgt = $urandom;
        push(1'b1, m_a, ip_a);
        push(1'b0, BCAST, tgt);
        bus.arp_rx_done = 1'b1;
        bus.arp_rx_type = 1'b0;
        bus.src_mac     = m_a;
        bus.src_ip      = ip_a;
        bus.req_start   = 1'b1;
        bus.req_ip      = tgt;
        tick();
        bus.arp_rx_done = 1'b0;
        bus.req_start   = 1'b0;
        wait_idle(100);
        m_b = rmac();
        rx_pulse(1'b1, m_b, tgt);
        tick();
        chk("arb_resolved", bus.resolved, 1);
        chk("arb_resolved_mac", bus.resolved_mac, m_b);

        // No reply at all: MAX_TRY requests then one fail pulse.
        tgt = $urandom;
        req_rise.delete();
        fp0 = n_failp;
        for (int i = 0; i < MAXT; i++) push(1'b0, BCAST, tgt);
        req_pulse(tgt);
        for (int k = 0; k < (MAXT + 2) * RETRY; k++) tick();
        chk("fail_pulses", n_failp - fp0, 1);
        chk("fail_requests", req_rise.size(), MAXT);
        chk("fail_queue_empty", exp_q.size(), 0);
        chk("fail_resolved", bus.resolved, 0);
        for (int i = 1; i < req_rise.size(); i++) begin
            g = req_rise[i] - req_rise[i-1];
            chk("retry_gap", (g >= RETRY) && (g <= RETRY + 4), 1);
        end

        // Reset while waiting for tx_done.
        tgt = $urandom;
        push(1'b0, BCAST, tgt);
        req_pulse(tgt);
        wait_rise(10);
        tx_stall = 1;
        tick(); tick(); tick();
        chk("wait_done_tx_en", bus.arp_tx_en, 0);
        chk("wait_done_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        chk_reset("mid_frame");
`ifdef ARP_CTRL_GRATUITOUS_EN
        push(1'b0, BCAST, BOARD_IP);
`endif
        rst = 1'b0;
        tx_stall = 0;
        fr0 = n_frames;
        wait_idle(50);
        for (int k = 0; k < 2 * RETRY; k++) tick();
`ifdef ARP_CTRL_GRATUITOUS_EN
        chk("post_reset_frames", n_frames - fr0, 1);
`else
        chk("post_reset_frames", n_frames - fr0, 0);
`endif
        chk("post_reset_queue", exp_q.size(), 0);
        chk("busy_when_idle", idle_busy_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
